// File: rtl/conv2d_stream_if.sv
// rtl/conv2d_stream_if.sv - coefficient, pixel and result signals of conv2d_stream
// Purpose: bundles the configuration strobe, the input pixel handshake and the
// result/status outputs of one convolution layer instance.
// Signals:
//   cfg_we, cfg_data          coefficient/bias write (engine input)
//   in_valid, in_data         raster-scan pixel (engine input)
//   in_ready                  engine accepts the pixel this cycle (engine output)
//   out_valid, out_data       one-cycle result strobe and value (engine output)
//   frame_done, busy          end-of-frame pulse and RUN/DRAIN status (engine output)
interface conv2d_stream_if #(
  parameter int DW = 16
);
  logic          cfg_we;
  logic [DW-1:0] cfg_data;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          frame_done;
  logic          busy;

  modport master (
    output cfg_we, cfg_data, in_valid, in_data,
    input  in_ready, out_valid, out_data, frame_done, busy
  );

  modport slave (
    input  cfg_we, cfg_data, in_valid, in_data,
    output in_ready, out_valid, out_data, frame_done, busy
  );
endinterface

// File: rtl/conv2d_stream.sv
// rtl/conv2d_stream.sv - streaming KxK 2-D convolution engine with line buffer
// Purpose: takes one raster-scan pixel per handshake, forms KxK windows, applies
// runtime-loaded fixed-point weights plus bias, rounds, saturates, optional ReLU,
// and emits one result per valid window position.
// Ports:
//   clk_in   clock
//   rst_n    synchronous active-low reset (aborts frame, clears coefficients)
//   bus      conv2d_stream_if slave: cfg_we/cfg_data, in_valid/in_data/in_ready,
//            out_valid/out_data, frame_done, busy
module conv2d_stream #(
  parameter int DW    = 16,
  parameter int K     = 3,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int FRAC  = 12,
  parameter int RELU  = 0
) (
  input  logic           clk_in,
  input  logic           rst_n,
  conv2d_stream_if.slave bus
);
  localparam int NW  = K * K;
  localparam int PW  = 2 * DW;
  localparam int ACC = 2 * DW + $clog2(NW) + 1;
  localparam int SRL = (K - 1) * IMG_W + K;
  localparam int IW  = $clog2(NW + 1);
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN   = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN   = RW'(K - 1);
  localparam logic [IW-1:0] BIAS_SLOT = IW'(NW);

  localparam logic signed [ACC-1:0] SAT_MAX = {{(ACC-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC-1:0] SAT_MIN = {{(ACC-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [ACC-1:0] HALF    = ACC'(1) <<< (FRAC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [DW-1:0]  w_q [NW];
  logic signed [DW-1:0]  bias_q;
  logic [IW-1:0]         cfg_idx_q;
  logic                  coef_ok_q;
  logic [RW-1:0]         row_q;
  logic [CW-1:0]         col_q;
  logic signed [DW-1:0]  sr_q [SRL];
  logic                  win_q, win_last_q;
  logic signed [PW-1:0]  prod_q [NW];
  logic                  v1_q, l1_q;
  logic signed [ACC-1:0] sum_q, sum_d;
  logic                  v2_q, l2_q;
  logic signed [ACC-1:0] rnd_d;
  logic [DW-1:0]         res_d;
  logic                  out_valid_q, frame_done_q;
  logic [DW-1:0]         out_data_q;

  logic                  in_ready_c;
  logic                  accept;
  logic                  last_pix;

  assign in_ready_c = (state_q == RUN) || ((state_q == IDLE) && coef_ok_q);
  assign accept     = bus.in_valid && in_ready_c;
  assign last_pix   = (row_q == ROW_LAST) && (col_q == COL_LAST);

  assign bus.in_ready   = in_ready_c;
  assign bus.busy       = (state_q == RUN) || (state_q == DRAIN);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // DRAIN ends on the edge after the final result strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (accept && last_pix) state_d = DRAIN;
      DRAIN:   if (frame_done_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Coefficient loading is only honoured in IDLE; the bias slot closes the set.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      for (int s = 0; s < NW; s++) w_q[s] <= '0;
      bias_q    <= '0;
      cfg_idx_q <= '0;
      coef_ok_q <= 1'b0;
    end else if ((state_q == IDLE) && bus.cfg_we) begin
      if (cfg_idx_q == BIAS_SLOT) begin
        bias_q    <= bus.cfg_data;
        coef_ok_q <= 1'b1;
        cfg_idx_q <= '0;
      end else begin
        for (int s = 0; s < NW; s++) begin
          if (cfg_idx_q == IW'(s)) w_q[s] <= bus.cfg_data;
        end
        cfg_idx_q <= cfg_idx_q + 1'b1;
      end
    end
  end

  // Position of the pixel being accepted; win_q marks that it completes a window.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      row_q      <= '0;
      col_q      <= '0;
      win_q      <= 1'b0;
      win_last_q <= 1'b0;
    end else begin
      win_q      <= accept && (row_q >= ROW_WIN) && (col_q >= COL_WIN);
      win_last_q <= accept && last_pix;
      if (accept) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // Line buffer and window as one shift chain: sr_q[0] is the newest pixel,
  // sr_q[d*IMG_W + e] is the pixel d rows up and e columns left of it.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      sr_q[0] <= bus.in_data;
      for (int i = 1; i < SRL; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  // Weight slot i*K+j pairs with window row i (0 = top), column j (0 = left).
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        prod_q[i*K+j] <= PW'(w_q[i*K+j]) * PW'(sr_q[(K-1-i)*IMG_W + (K-1-j)]);
      end
    end
    sum_q <= sum_d;
  end

  always_comb begin
    sum_d = ACC'(bias_q) <<< FRAC;
    for (int s = 0; s < NW; s++) sum_d = sum_d + ACC'(prod_q[s]);
  end

  // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
  always_comb begin
    rnd_d = (sum_q + HALF) >>> FRAC;
    if (rnd_d > SAT_MAX)      res_d = SAT_MAX[DW-1:0];
    else if (rnd_d < SAT_MIN) res_d = SAT_MIN[DW-1:0];
    else                      res_d = rnd_d[DW-1:0];
    if ((RELU != 0) && res_d[DW-1]) res_d = '0;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      l1_q         <= 1'b0;
      v2_q         <= 1'b0;
      l2_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      v1_q         <= win_q;
      l1_q         <= win_last_q;
      v2_q         <= v1_q;
      l2_q         <= l1_q;
      out_valid_q  <= v2_q;
      frame_done_q <= v2_q && l2_q;
      if (v2_q) out_data_q <= res_d;
    end
  end
endmodule

// File: tb/tb_conv2d_stream.sv
// tb/tb_conv2d_stream.sv - self-checking bench for conv2d_stream (ReLU off and on)
module tb_conv2d_stream;
  localparam int DW   = 16;
  localparam int K    = 3;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int FRAC = 12;
  localparam int NW   = K * K;
  localparam int OW   = W - K + 1;
  localparam int OH   = H - K + 1;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [DW-1:0] cfg_data;
  logic          in_valid;
  logic [DW-1:0] in_data;

  int n_cmp    = 0;
  int n_bad    = 0;
  int edge_cnt = 0;

  int pix_m [H][W];
  int w_m [NW];
  int bias_m;
  int exp_q0 [$];
  int exp_q1 [$];
  int fd_q0 [$];
  int fd_q1 [$];
  int lat_q [$];

  conv2d_stream_if #(.DW(DW)) if0 ();
  conv2d_stream_if #(.DW(DW)) if1 ();

  assign if0.cfg_we   = cfg_we;
  assign if0.cfg_data = cfg_data;
  assign if0.in_valid = in_valid;
  assign if0.in_data  = in_data;
  assign if1.cfg_we   = cfg_we;
  assign if1.cfg_data = cfg_data;
  assign if1.in_valid = in_valid;
  assign if1.in_data  = in_data;

  conv2d_stream #(.DW(DW), .K(K), .IMG_W(W), .IMG_H(H), .FRAC(FRAC), .RELU(0)) dut0 (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (if0)
  );

  conv2d_stream #(.DW(DW), .K(K), .IMG_W(W), .IMG_H(H), .FRAC(FRAC), .RELU(1)) dut1 (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (if1)
  );

  initial forever #5 clk_in = ~clk_in;

  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Window with top-left corner (r, c), evaluated straight from the frame array.
  function automatic int model(input int r, input int c, input bit relu);
    longint acc;
    acc = longint'(bias_m) * (longint'(1) <<< FRAC);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        acc += longint'(w_m[i*K+j]) * longint'(pix_m[r+i][c+j]);
    acc = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return int'(acc);
  endfunction

  always @(negedge clk_in) begin
    if (if0.out_valid) begin
      if (exp_q0.size() == 0) chk("dut0_spurious_out_valid", if0.out_valid, 0);
      else begin
        chk("dut0_out_data", $signed(if0.out_data), exp_q0.pop_front());
        chk("dut0_frame_done", if0.frame_done, fd_q0.pop_front());
        if (lat_q.size() == 0) chk("dut0_out_without_accept", if0.out_valid, 0);
        else chk("dut0_latency_edge", edge_cnt, lat_q.pop_front());
      end
    end else if (if0.frame_done) chk("dut0_fd_without_valid", if0.frame_done, 0);
    if (if1.out_valid) begin
      if (exp_q1.size() == 0) chk("dut1_spurious_out_valid", if1.out_valid, 0);
      else begin
        chk("dut1_out_data", $signed(if1.out_data), exp_q1.pop_front());
        chk("dut1_frame_done", if1.frame_done, fd_q1.pop_front());
      end
    end else if (if1.frame_done) chk("dut1_fd_without_valid", if1.frame_done, 0);
  end

  task automatic load_slots(input int lo, input int hi);
    for (int s = lo; s < hi; s++) begin
      @(negedge clk_in);
      cfg_we   = 1'b1;
      cfg_data = (s < NW) ? 16'(w_m[s]) : 16'(bias_m);
    end
    @(negedge clk_in);
    cfg_we = 1'b0;
  endtask

  task automatic set_weights(input int wv, input int bv);
    for (int s = 0; s < NW; s++) w_m[s] = wv;
    bias_m = bv;
  endtask

  // mode 0: 8r+c, 1: constant val, 2: uniform random in [-val, val]
  task automatic run_frame(input int mode, input int val, input int gap_pct, input bit noise,
                           input int stop_after);
    int idx;
    int guard;
    int t;
    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++)
        case (mode)
          0:       pix_m[rr][cc] = 8 * rr + cc;
          1:       pix_m[rr][cc] = val;
          default: pix_m[rr][cc] = int'($urandom_range(2 * val)) - val;
        endcase
    for (int rr = 0; rr < OH; rr++)
      for (int cc = 0; cc < OW; cc++) begin
        exp_q0.push_back(model(rr, cc, 1'b0));
        exp_q1.push_back(model(rr, cc, 1'b1));
        fd_q0.push_back((rr == OH - 1 && cc == OW - 1) ? 1 : 0);
        fd_q1.push_back((rr == OH - 1 && cc == OW - 1) ? 1 : 0);
      end
    idx   = 0;
    guard = 0;
    while (idx < stop_after && guard < 4000) begin
      @(negedge clk_in);
      in_valid = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
      in_data  = 16'(pix_m[idx / W][idx % W]);
      cfg_we   = noise && (idx > 0) && ($urandom_range(1) == 1);
      cfg_data = 16'($urandom);
      if (in_valid && if0.in_ready) begin
        if ((idx / W) >= K - 1 && (idx % W) >= K - 1) lat_q.push_back(edge_cnt + 4);
        idx++;
      end
      guard++;
    end
    chk("pixels_accepted", idx, stop_after);
    @(negedge clk_in);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    if (stop_after == W * H) begin
      t = 0;
      while (!if0.frame_done && t < 20) begin
        @(negedge clk_in);
        t++;
      end
      chk("frame_done_seen", if0.frame_done, 1);
      chk("busy_at_frame_done", if0.busy, 1);
      chk("in_ready_at_frame_done", if0.in_ready, 0);
      @(negedge clk_in);
      chk("busy_after_frame_done", if0.busy, 0);
      chk("in_ready_after_frame_done", if0.in_ready, 1);
      chk("results_outstanding", exp_q0.size() + exp_q1.size(), 0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_data = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_in_ready", if0.in_ready, 0);
    chk("rst_out_valid", if0.out_valid, 0);
    chk("rst_out_data", if0.out_data, 0);
    chk("rst_frame_done", if0.frame_done, 0);
    chk("rst_busy", if0.busy, 0);
    rst_n = 1'b1;

    in_valid = 1'b1;
    in_data  = 16'd7;
    repeat (4) begin
      @(negedge clk_in);
      chk("unconfigured_in_ready", if0.in_ready, 0);
      chk("unconfigured_busy", if0.busy, 0);
    end
    in_valid = 1'b0;

    set_weights(0, 0);
    w_m[4] = 4096;
    load_slots(0, NW + 1);
    chk("ready_after_cfg", if0.in_ready, 1);
    run_frame(0, 0, 0, 1'b0, W * H);
    run_frame(0, 0, 50, 1'b0, W * H);
    run_frame(0, 0, 0, 1'b1, W * H);
    run_frame(0, 0, 40, 1'b0, W * H);

    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < NW; s++) w_m[s] = int'($urandom_range(8192)) - 4096;
      bias_m = int'($urandom_range(200)) - 100;
      load_slots(0, NW + 1);
      run_frame(2, 2000, 25, 1'b0, W * H);
    end

    set_weights(0, 0);
    w_m[0] = 2048;
    load_slots(0, NW + 1);
    run_frame(1, 3, 0, 1'b0, W * H);
    run_frame(1, -3, 0, 1'b0, W * H);
    run_frame(1, 1, 0, 1'b0, W * H);

    set_weights(4096, 0);
    load_slots(0, NW + 1);
    run_frame(1, 32767, 0, 1'b0, W * H);
    run_frame(1, -32768, 0, 1'b0, W * H);

    set_weights(0, -5);
    load_slots(0, NW + 1);
    run_frame(2, 30000, 0, 1'b0, W * H);

    set_weights(0, 0);
    w_m[4] = 4096;
    load_slots(0, NW + 1);
    run_frame(0, 0, 0, 1'b0, 20);
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    fd_q0.delete();
    fd_q1.delete();
    lat_q.delete();
    repeat (2) @(negedge clk_in);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk_in);
      chk("post_reset_in_ready", if0.in_ready, 0);
      chk("post_reset_out_data", if0.out_data, 0);
      chk("post_reset_busy", if0.busy, 0);
    end
    in_valid = 1'b0;
    load_slots(0, NW);
    chk("ready_after_9_writes", if0.in_ready, 0);
    load_slots(NW, NW + 1);
    chk("ready_after_10_writes", if0.in_ready, 1);
    run_frame(0, 0, 20, 1'b0, W * H);

    repeat (5) @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
